// File: rtl/senna_enc_pkg.sv
// Shared types, defaults and size helpers for the Senna encode sequencer.
package senna_enc_pkg;

  localparam int unsigned DefLm = 2;
  localparam int unsigned DefM  = 6;
  localparam int unsigned DefKb = 2;
  localparam int unsigned DefPb = 2;

  // Cycles from an issue to its partial product appearing on pu_u.
  localparam int unsigned TagDepth = 4;
  // Tag p field is sized for up to 256 parity blocks.
  localparam int unsigned TagPw = 8;

  typedef enum logic [1:0] {StLoad, StRun, StDrain, StOut} state_e;

  typedef struct packed {
    logic             valid;
    logic             first;
    logic             last;
    logic [TagPw-1:0] p;
  } tag_t;

  function automatic int unsigned clog_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned calc_cpc(input int unsigned m, input int unsigned lm);
    return m / lm;
  endfunction

  function automatic int unsigned calc_nch(input int unsigned kb, input int unsigned m,
                                           input int unsigned lm);
    return kb * (m / lm);
  endfunction

  function automatic int unsigned calc_aw(input int unsigned pb, input int unsigned kb);
    return clog_w(pb * kb);
  endfunction

endpackage

// File: rtl/senna_encode_sequencer_circ_rotate.sv
// Combinational circulant rotate-right: o_data[i] = i_data[(i + i_shift) mod M].
module circ_rotate #(
  parameter int unsigned M = 6,
  localparam int unsigned Sw = (M > 1) ? $clog2(M) : 1
) (
  input  logic [M-1:0]  i_data,
  input  logic [Sw-1:0] i_shift,
  output logic [M-1:0]  o_data
);

  // Shift amount is always below M, so the two halves never overlap.
  always_comb begin
    o_data = (i_data >> i_shift) | (i_data << (M - 32'(i_shift)));
  end

endmodule

// File: rtl/senna_encode_sequencer.sv
// Sequences one Senna parity unit over a full QC-LDPC encoding pass: buffers the
// message, streams (chunk, pre-rotated circulant row) pairs, accumulates the
// partial products into parity blocks and hands them out over valid/ready.
module senna_encode_sequencer
  import senna_enc_pkg::*;
#(
  parameter int unsigned Lm = DefLm,
  parameter int unsigned M  = DefM,
  parameter int unsigned KB = DefKb,
  parameter int unsigned PB = DefPb,
  localparam int unsigned Aw = calc_aw(PB, KB),
  localparam int unsigned Pw = clog_w(PB)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [Lm-1:0] i_in_data,
  output logic [Aw-1:0] o_rom_addr,
  input  logic [M-1:0]  i_rom_data,
  output logic [Lm-1:0] o_pu_msg,
  output logic [M-1:0]  o_pu_f,
  input  logic [M-1:0]  i_pu_u,
  output logic          o_par_valid,
  input  logic          i_par_ready,
  output logic [M-1:0]  o_par_data,
  output logic [Pw-1:0] o_par_idx,
  output logic          o_busy
);

  localparam int unsigned Cpc = calc_cpc(M, Lm);
  localparam int unsigned Nch = calc_nch(KB, M, Lm);
  localparam int unsigned Cw  = clog_w(Nch);
  localparam int unsigned Sw  = clog_w(M);

  localparam logic [Cw-1:0] CLast     = Cw'(Nch - 1);
  localparam logic [Pw-1:0] PLast     = Pw'(PB - 1);
  localparam logic [1:0]    DrainLast = 2'(TagDepth - 1);

  state_e        r_state;
  logic [Cw-1:0] r_c;
  logic [Pw-1:0] r_p;
  logic [Pw-1:0] r_k;
  logic [1:0]    r_drain;
  logic          r_in_ready;
  logic          r_busy;
  logic          r_par_valid;

  logic [Lm-1:0] r_msg_buf [Nch];
  logic [M-1:0]  r_par_buf [PB];

  logic          r_s1_valid;
  logic [Cw-1:0] r_s1_c;
  logic [Lm-1:0] r_pu_msg;
  logic [M-1:0]  r_pu_f;
  logic [M-1:0]  r_acc;
  tag_t          r_tag [TagDepth];

  logic          w_load_acc;
  logic          w_out_done;
  logic          w_issue;
  tag_t          w_issue_tag;
  logic [Sw-1:0] w_shift;
  logic [M-1:0]  w_rot;
  logic [M-1:0]  w_sum;

  assign w_load_acc = (r_state == StLoad) && i_in_valid;
  assign w_out_done = (r_state == StOut) && i_par_ready && (r_k == PLast);
  assign w_issue    = (r_state == StRun);

  // Tag launched alongside each issue; it lines up with pu_u TagDepth cycles later.
  always_comb begin
    w_issue_tag       = '0;
    w_issue_tag.valid = w_issue;
    w_issue_tag.first = (r_c == '0);
    w_issue_tag.last  = (r_c == CLast);
    w_issue_tag.p     = TagPw'(r_p);
  end

  // ROM address is only meaningful while issuing.
  always_comb begin
    o_rom_addr = '0;
    if (w_issue) o_rom_addr = Aw'(32'(r_p) * KB + 32'(r_c) / Cpc);
  end

  // Rotation of the fetched row depends on the chunk's offset inside its circulant.
  assign w_shift = Sw'((32'(r_s1_c) % Cpc) * Lm);

  circ_rotate #(
    .M(M)
  ) u_circ_rotate (
    .i_data (i_rom_data),
    .i_shift(w_shift),
    .o_data (w_rot)
  );

  assign w_sum = r_tag[TagDepth-1].first ? i_pu_u : (r_acc ^ i_pu_u);

  // Control FSM: chunk/row counters, drain timer, output index and status flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StLoad;
      r_c         <= '0;
      r_p         <= '0;
      r_k         <= '0;
      r_drain     <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_par_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StLoad: begin
          if (i_in_valid) begin
            if (r_c == CLast) begin
              r_c        <= '0;
              r_state    <= StRun;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_c <= r_c + 1'b1;
            end
          end
        end
        StRun: begin
          if (r_c == CLast) begin
            r_c <= '0;
            if (r_p == PLast) begin
              r_p     <= '0;
              r_drain <= '0;
              r_state <= StDrain;
            end else begin
              r_p <= r_p + 1'b1;
            end
          end else begin
            r_c <= r_c + 1'b1;
          end
        end
        StDrain: begin
          if (r_drain == DrainLast) begin
            r_drain     <= '0;
            r_k         <= '0;
            r_par_valid <= 1'b1;
            r_state     <= StOut;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        StOut: begin
          if (i_par_ready) begin
            if (r_k == PLast) begin
              r_k         <= '0;
              r_c         <= '0;
              r_p         <= '0;
              r_par_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
              r_state     <= StLoad;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        default: r_state <= StLoad;
      endcase
    end
  end

  // Message buffer: filled in LOAD, wiped once the last parity block is taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || w_out_done) begin
      for (int i = 0; i < Nch; i++) r_msg_buf[i] <= '0;
    end else if (w_load_acc) begin
      r_msg_buf[r_c] <= i_in_data;
    end
  end

  // Issue pipeline: ROM-fetch stage, operand registers and tag delay line.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_c     <= '0;
      r_pu_msg   <= '0;
      r_pu_f     <= '0;
      for (int i = 0; i < TagDepth; i++) r_tag[i] <= '0;
    end else begin
      r_s1_valid <= w_issue;
      r_s1_c     <= r_c;
      r_tag[0]   <= w_issue_tag;
      for (int i = 1; i < TagDepth; i++) r_tag[i] <= r_tag[i-1];
      if (r_s1_valid) begin
        r_pu_msg <= r_msg_buf[r_s1_c];
        r_pu_f   <= w_rot;
      end else begin
        r_pu_msg <= '0;
        r_pu_f   <= '0;
      end
    end
  end

  // Parity accumulation: restart on a block's first chunk, commit on its last.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      for (int i = 0; i < PB; i++) r_par_buf[i] <= '0;
    end else if (r_tag[TagDepth-1].valid) begin
      r_acc <= w_sum;
      if (r_tag[TagDepth-1].last) r_par_buf[r_tag[TagDepth-1].p[Pw-1:0]] <= w_sum;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_busy      = r_busy;
  assign o_par_valid = r_par_valid;
  assign o_par_data  = r_par_valid ? r_par_buf[r_k] : '0;
  assign o_par_idx   = r_k;
  assign o_pu_msg    = r_pu_msg;
  assign o_pu_f      = r_pu_f;

endmodule

// File: tb/tb_senna_encode_sequencer.sv
// Bench for senna_encode_sequencer with a behavioural ROM and parity unit.
module tb_senna_encode_sequencer;

  localparam int Lm = 2;
  localparam int M  = 6;
  localparam int KB = 2;
  localparam int PB = 2;
  localparam int K  = KB * M;
  localparam int NCH = K / Lm;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [Lm-1:0] in_data;
  logic [1:0]    rom_addr;
  logic [M-1:0]  rom_data;
  logic [Lm-1:0] pu_msg;
  logic [M-1:0]  pu_f;
  logic [M-1:0]  pu_u;
  logic [M-1:0]  pu_stage;
  logic          par_valid;
  logic          par_ready;
  logic [M-1:0]  par_data;
  logic [0:0]    par_idx;
  logic          busy;

  logic [M-1:0]  rom [PB*KB];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int           idx;
    logic [M-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [K-1:0]       msg;
    logic [PB*KB*M-1:0] rom_flat;
    logic [M-1:0]       exp0;
    logic [M-1:0]       exp1;
    int                 bp;
  } vec_t;
  vec_t vecs[4];

  senna_encode_sequencer dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_data  (in_data),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_data),
    .o_pu_msg   (pu_msg),
    .o_pu_f     (pu_f),
    .i_pu_u     (pu_u),
    .o_par_valid(par_valid),
    .i_par_ready(par_ready),
    .o_par_data (par_data),
    .o_par_idx  (par_idx),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [M-1:0] rotr1(input logic [M-1:0] x);
    return {x[0], x[M-1:1]};
  endfunction

  function automatic logic [M-1:0] rotr(input logic [M-1:0] x, input int s);
    logic [M-1:0] y = x;
    for (int i = 0; i < s; i++) y = rotr1(y);
    return y;
  endfunction

  // Parity unit: XOR of the operand row rotated right by each set message bit's position.
  function automatic logic [M-1:0] pu_partial(input logic [Lm-1:0] msg, input logic [M-1:0] f);
    logic [M-1:0]  acc = '0;
    logic [Lm-1:0] m = msg;
    for (int j = 0; j < Lm; j++) begin
      if (m[0]) acc = acc ^ rotr(f, j);
      m = m >> 1;
    end
    return acc;
  endfunction

  // Reference encoder: bit k of circulant column b selects row k mod M of circulant (p,b).
  function automatic logic [M-1:0] ref_parity(input int p, input logic [K-1:0] msg);
    logic [M-1:0] acc = '0;
    logic [K-1:0] m = msg;
    for (int k = 0; k < K; k++) begin
      if (m[0]) acc = acc ^ rotr(rom[2'(p * KB + k / M)], k % M);
      m = m >> 1;
    end
    return acc;
  endfunction

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) begin
    pu_stage <= pu_partial(pu_msg, pu_f);
    pu_u     <= pu_stage;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_rom(input logic [PB*KB*M-1:0] flat);
    logic [PB*KB*M-1:0] f = flat;
    for (int i = 0; i < PB * KB; i++) begin
      rom[i] = f[M-1:0];
      f = f >> M;
    end
  endtask

  task automatic push_expected(input logic [K-1:0] msg);
    for (int p = 0; p < PB; p++) sb_q.push_back('{idx: p, data: ref_parity(p, msg)});
  endtask

  // Feeds one message; returns at the negedge of the cycle after the last accept.
  task automatic send_msg(input logic [K-1:0] msg, input bit hold_valid);
    logic [K-1:0] m = msg;
    check("load_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < NCH; c++) begin
      in_valid = 1'b1;
      in_data  = m[Lm-1:0];
      m = m >> Lm;
      @(negedge clk);
    end
    if (hold_valid) in_data = '1;
    else in_valid = 1'b0;
  endtask

  task automatic collect(input int exp_lat, input int bp);
    int n = 1;
    logic [M-1:0] d0;
    logic [0:0]   i0;
    bit stable;
    exp_t e;
    par_ready = 1'b1;
    check("busy_in_run", 32'(busy), 32'd1);
    while (!par_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!par_valid) begin
      check("par_valid_timeout", 32'd0, 32'd1);
      return;
    end
    check("first_valid_latency", 32'(n), 32'(exp_lat));
    if (bp > 0) begin
      par_ready = 1'b0;
      d0 = par_data;
      i0 = par_idx;
      stable = 1'b1;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        if (!par_valid || par_data !== d0 || par_idx !== i0) stable = 1'b0;
      end
      check("backpressure_stable", 32'(stable), 32'd1);
      par_ready = 1'b1;
    end
    for (int k = 0; k < PB; k++) begin
      check("par_valid_out", 32'(par_valid), 32'd1);
      if (sb_q.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("par_idx", 32'(par_idx), 32'(e.idx));
        check("par_data", 32'(par_data), 32'(e.data));
      end
      @(negedge clk);
    end
    check("back_to_load", {29'd0, in_ready, busy, par_valid}, 32'b100);
  endtask

  initial begin
    logic [K-1:0] msg;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    par_ready = 1'b1;
    for (int i = 0; i < PB * KB; i++) rom[i] = '0;
    repeat (3) @(negedge clk);

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_flags", {29'd0, busy, par_valid, par_idx}, 32'd0);
    check("rst_pu", {24'd0, pu_msg, pu_f}, 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_par_data", 32'(par_data), 32'd0);
    rst_n = 1'b1;

    vecs[0] = '{msg: 12'h000, rom_flat: {6'h2A, 6'h15, 6'h3F, 6'h01},
                exp0: 6'h00, exp1: 6'h00, bp: 0};
    vecs[1] = '{msg: 12'h001, rom_flat: {6'h00, 6'b100000, 6'h00, 6'b000011},
                exp0: 6'b000011, exp1: 6'b100000, bp: 0};
    vecs[2] = '{msg: 12'h008, rom_flat: {6'b101010, 6'b000010, 6'b111111, 6'b000001},
                exp0: 6'b001000, exp1: 6'b010000, bp: 0};
    vecs[3] = '{msg: 12'h040, rom_flat: {6'b110001, 6'b111111, 6'b010110, 6'b111111},
                exp0: 6'b010110, exp1: 6'b110001, bp: 5};

    for (int v = 0; v < 4; v++) begin
      load_rom(vecs[v].rom_flat);
      sb_q.push_back('{idx: 0, data: vecs[v].exp0});
      sb_q.push_back('{idx: 1, data: vecs[v].exp1});
      send_msg(vecs[v].msg, 1'b0);
      collect(17, vecs[v].bp);
    end

    // in_valid held high through RUN/DRAIN/OUT with junk data.
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < PB * KB; i++) rom[i] = 6'($urandom);
      msg = 12'($urandom);
      push_expected(msg);
      send_msg(msg, 1'b1);
      collect(17, 0);
    end
    in_valid = 1'b0;

    // Reset during the 5th RUN cycle, then a fresh message.
    for (int i = 0; i < PB * KB; i++) rom[i] = 6'($urandom) | 6'h01;
    msg = 12'($urandom) | 12'h001;
    send_msg(msg, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    check("midrun_rst_flags", {30'd0, busy, par_valid}, 32'd0);
    check("midrun_rst_pu_f", 32'(pu_f), 32'd0);
    check("midrun_rst_rom_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    msg = 12'($urandom);
    push_expected(msg);
    send_msg(msg, 1'b0);
    collect(17, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/senna_encode_sequencer.md
# senna_encode_sequencer

Controller that sequences the Senna parity generation unit across a full QC-LDPC encoding pass. It accepts a message in Lm-bit chunks and buffers it. It then streams (message chunk, pre-rotated circulant row) pairs into the parity unit, fetching rows from an external synchronous coefficient ROM. It XOR-accumulates the unit's partial products into PB parity blocks of M bits and hands them out over a valid/ready port. It sits between the message source, the coefficient ROM and one parity generation unit instance.

## Interface
- Lm, 2, message bits per chunk; M mod Lm == 0
- M, 6, circulant size (bits per parity block)
- KB, 2, message circulant columns; message length K = KB*M
- PB, 2, parity blocks per codeword
- Derived: CPC = M/Lm chunks per circulant; NCH = KB*CPC chunks per message; AW = max(1, clog2(PB*KB))

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  message chunk valid
- in_ready  out  1  chunk accepted when in_valid & in_ready
- in_data  in  Lm  message chunk, chunk 0 first; bit j = message bit c*Lm+j
- rom_addr  out  AW  coefficient ROM address = p*KB + b
- rom_data  in  M  first row of circulant (p,b), valid one cycle after rom_addr
- pu_msg  out  Lm  registered, to parity unit msg_inp
- pu_f  out  M  registered, to parity unit f_inp
- pu_u  in  M  parity unit u_reg
- par_valid  out  1  parity block valid
- par_ready  in  1  downstream accepts block
- par_data  out  M  parity block
- par_idx  out  clog2(PB) or 1  index p of par_data
- busy  out  1  high in RUN, DRAIN, OUT

## Operation
- States: LOAD (reset state), RUN, DRAIN, OUT.
- LOAD: in_ready=1. Each accepted chunk is written to msg_buf[c], and c increments. Accepting chunk NCH-1 moves to RUN.
- RUN: one issue per cycle, p outer (0..PB-1), c inner (0..NCH-1), PB*NCH issues total.
- Issue (p,c): b = c / CPC, r = (c mod CPC)*Lm, rom_addr = p*KB+b.
- Next cycle: pu_f <= rom_data rotated right by r (pu_f[i] = rom_data[(i+r) mod M]) and pu_msg <= msg_buf[c].
- A tag pipeline carries {valid, first=(c==0), last=(c==NCH-1), p}, aligned to pu_u.
- Accumulation on an aligned valid tag:
  - acc <= first ? pu_u : acc ^ pu_u.
  - If last: par_buf[p] <= (first ? pu_u : acc ^ pu_u).
- After the last issue the block enters DRAIN for 4 cycles, then OUT.
- OUT: par_valid=1, par_data=par_buf[k], par_idx=k for k=0..PB-1.
  - k advances on par_valid & par_ready.
  - Handshake on k=PB-1 returns to LOAD, clears msg_buf and counters.
- Outside RUN and its tag flush, pu_msg=0 and pu_f=0, so the parity unit sees zero operands.
- in_ready=0 outside LOAD. in_valid is ignored there and no chunk is lost or stored.
- par_data and par_idx are stable while par_valid & !par_ready.
- Reset (rst=0) at any cycle, including mid-RUN or mid-OUT:
  - next state LOAD; all counters, acc, tags, msg_buf and par_buf cleared.
  - Outputs: in_ready=1, par_valid=0, busy=0, pu_msg=0, pu_f=0, rom_addr=0, par_data=0, par_idx=0.
- The parity unit's own reset is driven by the top level, not by this block.

## Timing
- Issue in cycle t means: rom_addr in t, rom_data in t+1, pu_msg/pu_f in t+2, parity unit internal register in t+3, pu_u in t+4. The tag delay is 4.
- If the last chunk is accepted at the edge ending cycle T:
  - RUN occupies T+1 .. T+PB*NCH.
  - DRAIN occupies the next 4 cycles.
  - par_valid first rises at T+PB*NCH+5 (cycle 17 after T for the defaults).
- Throughput: one chunk per cycle in LOAD and one issue per cycle in RUN, with no bubbles.
- rom_addr is combinational from the counters, only in RUN; otherwise it is 0.

## Structure
- Shared package senna_enc_pkg holds:
  - the state enum {LOAD, RUN, DRAIN, OUT};
  - the default Lm/M/KB/PB values;
  - functions for CPC, NCH and AW;
  - the tag struct {valid, first, last, p}.
- One sub-module is natural: circ_rotate (parameter M, input data M, shift clog2(M), output rotated right). It is purely combinational.
- The parity unit is not instantiated here; it is wired at the encoder top level.

## Test plan
- Zero message: 6 chunks of 2'b00, with any ROM contents -> par_data 6'h00 for p=0 and p=1, in order par_idx 0, 1; first par_valid 17 cycles after the last accept.
- Single bit: chunk0=2'b01, others 0; rom[0]=6'b000011, rom[2]=6'b100000 -> parity0=6'b000011, parity1=6'b100000.
- Rotation: only message bit 3 set (chunk1=2'b10); rom[0]=6'b000001, rom[2]=6'b000010 -> parity0=6'b001000, parity1=6'b010000.
- Backpressure: hold par_ready=0 for 5 cycles in OUT -> par_valid stays 1 with par_data/par_idx stable; release -> two blocks emitted, then in_ready=1.
- in_valid held high through RUN/DRAIN/OUT -> no extra chunk stored; the next message after return to LOAD encodes correctly, checked against a software model using random ROM and message.
- Reset at the 5th RUN cycle -> next cycle: LOAD, in_ready=1, busy=0, pu_f=0, par_valid=0; a fresh message encodes correctly.
